// File: rtl/downscale_result_writer.sv
// Captures the downscaled DST_HxDST_W image into a byte-wide result BRAM, one pixel per cycle,
// with a synchronous host read port. Optional checksum enabled by defining DOWNSCALE_CHECKSUM_EN.
module downscale_result_writer #(
    parameter int DST_W = 16,
    parameter int DST_H = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  image_in [0:DST_H-1][0:DST_W-1],
    input  logic [15:0] host_rd_addr,
    output logic [7:0]  host_rd_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] wr_count,
    output logic [15:0] checksum
);

    localparam int DEPTH = DST_W * DST_H;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RW    = (DST_H > 1) ? $clog2(DST_H) : 1;
    localparam int CW    = (DST_W > 1) ? $clog2(DST_W) : 1;
    localparam logic [16:0]   DEPTH_W  = 17'(DEPTH);
    localparam logic [RW-1:0] ROW_LAST = RW'(DST_H - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(DST_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

    state_t        state_reg, state_next;
    logic [RW-1:0] row_reg;
    logic [CW-1:0] col_reg;
    logic [15:0]   wr_count_reg;
    logic [7:0]    rd_data_reg;
    logic [7:0]    mem [0:DEPTH-1];

    logic        start_accept;
    logic        last_pix;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_pixel;

    // A start is only honoured outside S_WRITE, so a held start re-triggers from S_DONE.
    assign start_accept = start && (state_reg != S_WRITE);
    assign last_pix     = (row_reg == ROW_LAST) && (col_reg == COL_LAST);
    assign wr_addr      = 16'(row_reg) * 16'(DST_W) + 16'(col_reg);
    assign wr_pixel     = image_in[row_reg][col_reg];
    assign wr_en        = (state_reg == S_WRITE) && ({1'b0, wr_addr} < DEPTH_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start)    state_next = S_WRITE;
            S_WRITE: if (last_pix) state_next = S_DONE;
            S_DONE:  if (start)    state_next = S_WRITE;
            default:               state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            S_WRITE: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_reg      <= '0;
            col_reg      <= '0;
            wr_count_reg <= '0;
        end else if (start_accept) begin
            row_reg      <= '0;
            col_reg      <= '0;
            wr_count_reg <= '0;
        end else if (state_reg == S_WRITE) begin
            wr_count_reg <= wr_count_reg + 16'd1;
            if (last_pix) begin
                row_reg <= '0;
                col_reg <= '0;
            end else if (col_reg == COL_LAST) begin
                col_reg <= '0;
                row_reg <= row_reg + RW'(1);
            end else begin
                col_reg <= col_reg + CW'(1);
            end
        end
    end

    // BRAM contents deliberately survive reset; only the output register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[AW-1:0]] <= wr_pixel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_reg <= 8'h00;
        end else if ({1'b0, host_rd_addr} < DEPTH_W) begin
            rd_data_reg <= mem[host_rd_addr[AW-1:0]];
        end else begin
            rd_data_reg <= 8'h00;
        end
    end

    assign host_rd_data = rd_data_reg;
    assign wr_count     = wr_count_reg;

`ifdef DOWNSCALE_CHECKSUM_EN
    logic [15:0] checksum_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum_reg <= 16'h0000;
        end else if (start_accept) begin
            checksum_reg <= 16'h0000;
        end else if (state_reg == S_WRITE) begin
            checksum_reg <= checksum_reg + {8'h00, wr_pixel};
        end
    end

    assign checksum = checksum_reg;
`else
    assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_downscale_result_writer.sv
// Randomised and directed bench for downscale_result_writer against a pixel-index reference model.
module tb_downscale_result_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  img [0:15][0:15];
    logic [15:0] host_rd_addr = 16'd0;
    logic [7:0]  host_rd_data;
    logic        busy, done;
    logic [15:0] wr_count, checksum;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    downscale_result_writer #(.DST_W(16), .DST_H(16)) dut (
        .clk(clk), .rst(rst), .start(start), .image_in(img),
        .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data),
        .busy(busy), .done(done), .wr_count(wr_count), .checksum(checksum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: a capture is "k pixels copied so far", pixel k lives at linear index k.
    logic [7:0] m_mem [256];
    bit         m_val [256];
    bit         m_active = 0, m_done = 0, m_rd_known = 0;
    int         m_k = 0, m_sum = 0;
    logic [7:0] m_rd = 8'h00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 0; m_done = 0; m_k = 0; m_sum = 0;
            m_rd = 8'h00; m_rd_known = 1;
        end else begin
            if (int'(host_rd_addr) >= 256) begin
                m_rd = 8'h00; m_rd_known = 1;
            end else begin
                m_rd = m_mem[host_rd_addr]; m_rd_known = m_val[host_rd_addr];
            end
            if (m_active) begin
                m_mem[m_k] = img[m_k / 16][m_k % 16];
                m_val[m_k] = 1;
                m_sum = (m_sum + int'(img[m_k / 16][m_k % 16])) % 65536;
                m_k++;
                if (m_k == 256) begin m_active = 0; m_done = 1; end
            end else if (start) begin
                m_active = 1; m_done = 0; m_k = 0; m_sum = 0;
            end
        end
    end

    function automatic logic [15:0] exp_ck(input int s);
`ifdef DOWNSCALE_CHECKSUM_EN
        return 16'(s);
`else
        return 16'h0000 + 16'(s * 0);
`endif
    endfunction

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_active));
        chk("done", 32'(done), 32'(m_done));
        chk("wr_count", 32'(wr_count), 32'(m_k));
        if (m_done || rst || (!m_active && m_k == 0))
            chk("checksum", 32'(checksum), 32'(exp_ck(m_sum)));
        if (m_rd_known) chk("rd_data", 32'(host_rd_data), 32'(m_rd));
    end

    task automatic fill(input int mode);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                case (mode)
                    0: img[r][c] = 8'(r * 16 + c);
                    1: img[r][c] = 8'hFF;
                    2: img[r][c] = 8'h01;
                    default: img[r][c] = 8'($urandom_range(0, 255));
                endcase
    endtask

    // Drives start over exactly one edge; returns #1 after that edge with its cycle number.
    task automatic pulse_start(output int n);
        start = 1'b1;
        @(posedge clk); #1;
        n = cyc;
        start = 1'b0;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 400) begin
            cnt++;
            @(posedge clk); #1;
        end
    endtask

    int n0, len;
    logic [15:0] ck_ramp, ck_ff, ck_01;

    initial begin
        ck_ramp = 16'h0000; ck_ff = 16'h0000; ck_01 = 16'h0000;
`ifdef DOWNSCALE_CHECKSUM_EN
        ck_ramp = 16'h7F80; ck_ff = 16'hFF00; ck_01 = 16'h0100;
`endif
        fill(0);
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_wr_count", 32'(wr_count), 0);
        chk("rst_checksum", 32'(checksum), 0);
        chk("rst_rd_data", 32'(host_rd_data), 0);
        start = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_rst", 32'(busy), 0);

        // Ramp capture and full readback
        pulse_start(n0);
        wait_idle(len);
        chk("ramp_busy_len", 32'(len), 256);
        chk("ramp_done_edge", 32'(cyc - n0), 256);
        chk("ramp_done", 32'(done), 1);
        chk("ramp_wr_count", 32'(wr_count), 256);
        chk("ramp_checksum", 32'(checksum), 32'(ck_ramp));
        for (int i = 0; i < 256; i++) begin
            host_rd_addr = 16'(i);
            @(posedge clk); #1;
            chk("ramp_read", 32'(host_rd_data), 32'(i));
        end
        host_rd_addr = 16'd256;
        @(posedge clk); #1;
        chk("read_256", 32'(host_rd_data), 0);
        host_rd_addr = 16'hFFFF;
        @(posedge clk); #1;
        chk("read_ffff", 32'(host_rd_data), 0);

        // Overflow wrap, then restart from S_DONE with a same-edge read of address 5
        fill(1);
        pulse_start(n0);
        wait_idle(len);
        chk("ff_checksum", 32'(checksum), 32'(ck_ff));
        fill(2);
        pulse_start(n0);
        repeat (5) @(posedge clk);
        #1 host_rd_addr = 16'd5;
        @(posedge clk); #1;
        chk("rfirst_old", 32'(host_rd_data), 32'h0000_00FF);
        @(posedge clk); #1;
        chk("rfirst_new", 32'(host_rd_data), 32'h0000_0001);
        wait_idle(len);
        chk("restart_len", 32'(len + 7), 256);
        chk("restart_done_edge", 32'(cyc - n0), 256);
        chk("ones_checksum", 32'(checksum), 32'(ck_01));

        // Start pulses while busy are ignored
        fill(3);
        pulse_start(n0);
        repeat (9) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (189) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_idle(len);
        chk("busy_start_done_edge", 32'(cyc - n0), 256);
        chk("busy_start_done", 32'(done), 1);

        // Reset mid-write
        fill(3);
        pulse_start(n0);
        len = 0;
        while (wr_count != 16'd100 && len < 400) begin
            len++;
            @(posedge clk); #1;
        end
        chk("mid_wr_count", 32'(wr_count), 100);
        rst = 1'b1;
        start = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_wr_count", 32'(wr_count), 0);
        chk("mid_rst_rd_data", 32'(host_rd_data), 0);
        @(posedge clk); #1;
        start = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            host_rd_addr = 16'(i);
            @(posedge clk); #1;
            chk("retained_read", 32'(host_rd_data), 32'(img[i / 16][i % 16]));
        end
        fill(3);
        pulse_start(n0);
        wait_idle(len);
        chk("after_rst_len", 32'(len), 256);
        chk("after_rst_wr_count", 32'(wr_count), 256);

        // Randomised phase: random addresses, random (sometimes held) starts
        for (int t = 0; t < 3000; t++) begin
            host_rd_addr = 16'($urandom_range(0, 300));
            if (!busy && !start && ($urandom_range(0, 3) == 0)) fill(3);
            start = ($urandom_range(0, 39) == 0) || (start && $urandom_range(0, 1) == 0);
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_idle(len);
        chk("final_idle", 32'(busy), 0);

        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/downscale_result_writer.md
# downscale_result_writer

Downstream stage of the sequential downscaler. When it receives a start pulse, it copies the finished `DST_H`×`DST_W` output array, one pixel per cycle in raster order, into an internal byte-wide result BRAM. The host (JTAG-style debug side) reads results from that BRAM through a synchronous read port. The block reports busy/done status, a pixel write count and an optional checksum.

## Interface
Parameters:
- `DST_W`, 16: output image width in pixels.
- `DST_H`, 16: output image height in pixels.
- `DEPTH`, `DST_W*DST_H` (localparam): number of result BRAM entries.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: begin capture; sampled high on a `clk` edge. Normally driven by the downscaler's done.
- `image_in`  in  [7:0] x [0:DST_H-1][0:DST_W-1]: downscaled image; must stay stable from start until `done`.
- `host_rd_addr`  in  16: host read address, linear `row*DST_W+col`.
- `host_rd_data`  out  8: registered read data.
- `busy`  out  1: high while the block is writing.
- `done`  out  1: capture complete; held until the next accepted start.
- `wr_count`  out  16: pixels written since the last accepted start.
- `checksum`  out  16: 16-bit sum of written pixels (see Configuration).

## Operation
States:
- **S_IDLE**: `busy=0`, `done=0`.
  - On start: clear `row`, `col`, `wr_count` and the checksum; set `busy=1`; go to S_WRITE.
- **S_WRITE**: every cycle, write `image_in[row][col]` to `mem[row*DST_W+col]` and increment `wr_count`.
  - `col` increments and wraps at `DST_W-1` to 0, which increments `row`.
  - On the write of the last pixel (`row=DST_H-1`, `col=DST_W-1`): set `busy=0`, `done=1`, go to S_DONE.
  - `start` is ignored in this state.
- **S_DONE**: `done=1` is held.
  - On start: clear `done` and the counters, set `busy=1`, go to S_WRITE. This is a full restart.

Arithmetic and counters:
- `row` and `col` counters are wide enough for `DST_H` and `DST_W` respectively.
- The address product is computed at 16 bits.
- `wr_count` ends at exactly `DEPTH`.

Result BRAM:
- Single write port (internal), separate read port (host).
- Read-first: reading the address being written on the same edge returns the old byte.
- Host reads are allowed in any state, including during S_WRITE.
- `host_rd_addr >= DEPTH` returns `8'h00`.

Reset:
- Any time, including mid-write: `state=S_IDLE`, `busy=0`, `done=0`, `wr_count=0`, `checksum=0`, `host_rd_data=8'h00`.
- BRAM contents are not cleared. Bytes already written are retained.

## Timing
- Start sampled at edge N: `busy=1` after edge N.
- Writes occur at edges N+1 … N+DEPTH (256 for the defaults).
- At edge N+DEPTH: `busy` falls, `done` rises. `busy` is high for exactly `DEPTH` cycles.
- `wr_count` equals k after the k-th write edge.
- Host read latency is 1 cycle: address sampled at edge M, data valid after edge M.
- A start held high for multiple cycles is accepted once. Further starts are ignored while busy.
- After done, a start still held high is accepted and triggers a restart.

## Configuration
- `DOWNSCALE_CHECKSUM_EN` defined:
  - `checksum` accumulates a wrap-around 16-bit sum of every byte written, zero-extended.
  - The sum is cleared on an accepted start and is valid when `done=1`.
- Not defined:
  - `checksum` is tied to `16'h0000`. The port remains present and no adder is synthesised.

## Test plan
- **Reset values**: assert `rst` with `start=1` → `busy=0`, `done=0`, `wr_count=0`, `checksum=0`, `host_rd_data=0`; the state stays idle until rst is released.
- **Ramp capture**: `image_in[r][c]=r*16+c`, 1-cycle start → `busy` high for 256 cycles, `done` rises at edge N+256, `wr_count=256`. Read addresses 0…255 → data equals the address, each one cycle after presentation. `checksum=16'h7F80` with the macro, `16'h0000` without.
- **Overflow wrap**: all pixels `8'hFF` → `checksum=16'hFF00` with the macro. A second start from S_DONE with all `8'h01` → `checksum=16'h0100`, `done` low for 256 cycles, then high.
- **Start while busy**: extra start pulses at write cycles 10 and 200 → ignored; `done` still rises exactly 256 cycles after the first start.
- **Reset mid-write**: assert `rst` when `wr_count=100` → all outputs return to reset values. Addresses 0…99 still read the old pattern. A new start completes normally with 256 writes.
- **Host read edge cases**: `host_rd_addr=256` → `8'h00`. Reading address 5 on the same edge it is being written → previous byte; the next read returns the new byte.
